// File: rtl/usbf_crc_engine.sv
// Sequential CRC engine for the USB function core: accumulates an LSB-first CRC over
// multi-beat packets, producing the TX CRC field and the RX residue check.
module usbf_crc_engine #(
    parameter int unsigned      CRC_W   = 5,
    parameter logic [CRC_W-1:0] POLY    = 5'b00101,
    parameter logic [CRC_W-1:0] INIT    = '1,
    parameter logic [CRC_W-1:0] RESIDUE = 5'b01100,
    parameter int unsigned      DATA_W  = 8,
    parameter int unsigned      NB_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sop,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    input  logic              din_last,
    input  logic [NB_W-1:0]   din_nbits,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_valid,
    output logic              crc_ok,
    output logic              busy,
    output logic [15:0]       bit_cnt,
    output logic              err_proto
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CRC_W-1:0]  c_q, c_d;
    logic [CRC_W-1:0]  c_start, c_beat;
    logic [CRC_W-1:0]  crc_out_q, crc_out_d;
    logic              crc_ok_q, crc_ok_d;
    logic              crc_valid_q, crc_valid_d;
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       beat_bits;
    logic [15:0]       cnt_base;
    logic [16:0]       cnt_sum;
    logic              accept;
    logic              fb;

    // Transmitted field: complemented and bit-reversed so that crc_out[0] leads on the wire.
    function automatic logic [CRC_W-1:0] to_field(input logic [CRC_W-1:0] c);
        logic [CRC_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(CRC_W); i++) begin
            r[i] = ~c[int'(CRC_W) - 1 - i];
        end
        return r;
    endfunction

    always_comb begin
        beat_bits = 16'(DATA_W);
        if (din_last) begin
            if (din_nbits == '0) begin
                beat_bits = 16'(DATA_W);
            end else if (16'(din_nbits) > 16'(DATA_W)) begin
                beat_bits = 16'(DATA_W);
            end else begin
                beat_bits = 16'(din_nbits);
            end
        end
    end

    assign c_start = sop ? INIT : c_q;

    // Whole beat folded in one cycle; bits beyond beat_bits leave the register untouched.
    always_comb begin
        c_beat = c_start;
        fb     = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (16'(i) < beat_bits) begin
                fb     = din[i] ^ c_beat[CRC_W-1];
                c_beat = {c_beat[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
            end
        end
    end

    assign cnt_base = sop ? 16'h0000 : cnt_q;
    assign cnt_sum  = {1'b0, cnt_base} + {1'b0, beat_bits};

    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        crc_out_d   = crc_out_q;
        crc_ok_d    = crc_ok_q;
        crc_valid_d = 1'b0;
        err_d       = 1'b0;
        accept      = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (sop) begin
                        accept = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                StRun: begin
                    accept = 1'b1;
                    // A sop here aborts the open packet; the beat restarts from INIT.
                    if (sop) begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (accept) begin
            c_d   = c_beat;
            cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            if (din_last) begin
                state_d     = StIdle;
                crc_valid_d = 1'b1;
                crc_out_d   = to_field(c_beat);
                crc_ok_d    = (c_beat == RESIDUE);
            end else begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            c_q         <= INIT;
            cnt_q       <= 16'h0000;
            crc_out_q   <= to_field(INIT);
            crc_ok_q    <= 1'b0;
            crc_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            crc_out_q   <= crc_out_d;
            crc_ok_q    <= crc_ok_d;
            crc_valid_q <= crc_valid_d;
            err_q       <= err_d;
        end
    end

    assign crc_out   = crc_out_q;
    assign crc_ok    = crc_ok_q;
    assign crc_valid = crc_valid_q;
    assign err_proto = err_q;
    assign bit_cnt   = cnt_q;
    assign busy      = (state_q == StRun);

endmodule
